// File: rtl/alu_share_ctrl_if.sv
// Request, response and shared-ALU signal bundle for alu_share_ctrl.
// The NZCV flag signals exist only when ALU_SHARE_FLAGS_EN is defined.
interface alu_share_ctrl_if #(
    parameter int unsigned N   = 32,
    parameter int unsigned OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic           rsp0_valid;
    logic           rsp0_ready;
    logic [N-1:0]   rsp0_result;
    logic           rsp1_valid;
    logic           rsp1_ready;
    logic [N-1:0]   rsp1_result;
    logic           alu_start;
    logic [OPW-1:0] alu_op;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [N-1:0]   alu_result;
    logic           busy;
`ifdef ALU_SHARE_FLAGS_EN
    logic [3:0]     rsp0_flags;
    logic [3:0]     rsp1_flags;
    logic [3:0]     alu_flags;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result, alu_flags,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_flags,
        output alu_start, alu_op, alu_a, alu_b, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result, alu_flags,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_flags,
        input  alu_start, alu_op, alu_a, alu_b, busy
    );
`else
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result,
        output rsp1_valid, rsp1_result,
        output alu_start, alu_op, alu_a, alu_b, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result,
        input  rsp1_valid, rsp1_result,
        input  alu_start, alu_op, alu_a, alu_b, busy
    );
`endif
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_SHARE_FLAGS_EN to carry NZCV flags alongside the result.
module alu_share_ctrl #(
    parameter int unsigned N   = 32,
    parameter int unsigned OPW = 4,
    parameter int unsigned LAT = 1
) (
    input logic             clk,
    input logic             rst,
    alu_share_ctrl_if.slave io_bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StExec  = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;
    localparam logic [3:0] LastCnt = 4'(LAT - 1);

    logic [1:0]     r_state;
    logic           r_prio;
    logic           r_owner;
    logic           r_start;
    logic [3:0]     r_cnt;
    logic [OPW-1:0] r_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_result;
`ifdef ALU_SHARE_FLAGS_EN
    logic [3:0]     r_flags;
`endif

    logic w_idle;
    logic w_resp;
    logic w_gnt0;
    logic w_gnt1;
    logic w_rsp_hs;

    assign w_idle   = (r_state == StIdle);
    assign w_resp   = (r_state == StResp);
    // r_prio names the requester that wins a tie.
    assign w_gnt0   = io_bus.req0_valid & (~io_bus.req1_valid | ~r_prio);
    assign w_gnt1   = io_bus.req1_valid & (~io_bus.req0_valid | r_prio);
    assign w_rsp_hs = w_resp & (r_owner ? io_bus.rsp1_ready : io_bus.rsp0_ready);

    assign io_bus.req0_ready  = w_idle & w_gnt0;
    assign io_bus.req1_ready  = w_idle & w_gnt1;
    assign io_bus.rsp0_valid  = w_resp & ~r_owner;
    assign io_bus.rsp1_valid  = w_resp & r_owner;
    assign io_bus.rsp0_result = r_result;
    assign io_bus.rsp1_result = r_result;
    assign io_bus.alu_start   = r_start;
    assign io_bus.alu_op      = r_op;
    assign io_bus.alu_a       = r_a;
    assign io_bus.alu_b       = r_b;
    assign io_bus.busy        = ~w_idle;
`ifdef ALU_SHARE_FLAGS_EN
    assign io_bus.rsp0_flags  = r_flags;
    assign io_bus.rsp1_flags  = r_flags;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_start  <= 1'b0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
`ifdef ALU_SHARE_FLAGS_EN
            r_flags  <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_op    <= w_gnt1 ? io_bus.req1_op : io_bus.req0_op;
                        r_a     <= w_gnt1 ? io_bus.req1_a  : io_bus.req0_a;
                        r_b     <= w_gnt1 ? io_bus.req1_b  : io_bus.req0_b;
                        r_owner <= w_gnt1;
                        r_prio  <= ~w_gnt1;
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LastCnt) begin
                        r_result <= io_bus.alu_result;
`ifdef ALU_SHARE_FLAGS_EN
                        r_flags  <= io_bus.alu_flags;
`endif
                        r_state  <= StResp;
                    end
                end
                StResp: begin
                    if (w_rsp_hs) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table, scoreboard queues and
// hand-written timing, contention, backpressure and mid-operation reset sequences.
module tb_alu_share_ctrl;
    localparam int unsigned N    = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned LAT  = 2;
    localparam int unsigned LAT4 = 4;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [N-1:0]   exp;
        logic [3:0]     fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   hcyc;
    vec_t tbl [8];
    vec_t q0 [$];
    vec_t q1 [$];
    vec_t cur0;
    vec_t cur1;
    vec_t e0;
    vec_t e1;
    int   glog [$];
    int   gcyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl_if #(.N(N), .OPW(OPW)) bus ();
    alu_share_ctrl_if #(.N(N), .OPW(OPW)) bus4 ();

    alu_share_ctrl #(.N(N), .OPW(OPW), .LAT(LAT)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    alu_share_ctrl #(.N(N), .OPW(OPW), .LAT(LAT4)) u_dut4 (
        .clk    (clk),
        .rst    (rst4),
        .io_bus (bus4)
    );

    // Reference ALU: op 0 is NOT with the >>31 width quirk, then ADD, XOR, SUB.
    function automatic logic [N-1:0] alu_f(input logic [OPW-1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        case (op)
            4'd0:    return (~a) >> 31;
            4'd1:    return a + b;
            4'd2:    return a ^ b;
            default: return a - b;
        endcase
    endfunction

    assign bus.alu_result  = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus4.alu_result = alu_f(bus4.alu_op, bus4.alu_a, bus4.alu_b);
`ifdef ALU_SHARE_FLAGS_EN
    assign bus.alu_flags  = {bus.alu_result[N-1], bus.alu_result == '0, 2'b00};
    assign bus4.alu_flags = {bus4.alu_result[N-1], bus4.alu_result == '0, 2'b00};
`endif

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired, expected event did not occur (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) begin
                q0.push_back(cur0);
                glog.push_back(0);
                gcyc.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                q1.push_back(cur1);
                glog.push_back(1);
                gcyc.push_back(cyc);
            end
            if (bus.rsp0_valid || bus.rsp1_valid)
                chk("rsp_exclusive", N'(bus.rsp0_valid & bus.rsp1_valid), '0);
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                chk("rsp0_issuer", q0.size(), 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("rsp0_result", bus.rsp0_result, e0.exp);
`ifdef ALU_SHARE_FLAGS_EN
                    chk("rsp0_flags", N'(bus.rsp0_flags), N'(e0.fl));
`endif
                end
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                chk("rsp1_issuer", q1.size(), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("rsp1_result", bus.rsp1_result, e1.exp);
`ifdef ALU_SHARE_FLAGS_EN
                    chk("rsp1_flags", N'(bus.rsp1_flags), N'(e1.fl));
`endif
                end
            end
        end
    end

    task automatic drive(input int k, input int idx);
        int t = 0;
        if (k == 0) begin
            cur0 = tbl[idx];
            bus.req0_op = tbl[idx].op; bus.req0_a = tbl[idx].a; bus.req0_b = tbl[idx].b;
            bus.req0_valid = 1'b1;
        end else begin
            cur1 = tbl[idx];
            bus.req1_op = tbl[idx].op; bus.req1_a = tbl[idx].a; bus.req1_b = tbl[idx].b;
            bus.req1_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (k == 0 ? bus.req0_ready : bus.req1_ready) break;
            t++;
            if (t > 50) begin
                tmo(k == 0 ? "req0_accept" : "req1_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (k == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic single_op(input int idx);
        cur0 = tbl[idx];
        bus.req0_op = tbl[idx].op; bus.req0_a = tbl[idx].a; bus.req0_b = tbl[idx].b;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("single_accept", N'(bus.req0_ready), 1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("single_start_t1", N'(bus.alu_start), 1);
        chk("single_alu_a", bus.alu_a, tbl[idx].a);
        chk("single_busy", N'(bus.busy), 1);
        for (int i = 1; i < int'(LAT); i++) begin
            @(negedge clk);
            chk("single_start_pulse", N'(bus.alu_start), 0);
            chk("single_rsp_early", N'(bus.rsp0_valid), 0);
        end
        @(negedge clk);
        chk("single_rsp_valid", N'(bus.rsp0_valid), 1);
        chk("single_rsp_result", bus.rsp0_result, tbl[idx].exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        tbl[0] = '{4'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 4'b0000};
        tbl[1] = '{4'd0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
        tbl[2] = '{4'd1, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 4'b0000};
        tbl[3] = '{4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'b1000};
        tbl[4] = '{4'd3, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 4'b0000};
        tbl[5] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100};
        tbl[6] = '{4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1000};
        tbl[7] = '{4'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};

        rst = 1'b1; rst4 = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus4.req0_valid = 1'b0; bus4.req0_op = '0; bus4.req0_a = '0; bus4.req0_b = '0;
        bus4.req1_valid = 1'b0; bus4.req1_op = '0; bus4.req1_a = '0; bus4.req1_b = '0;
        bus4.rsp0_ready = 1'b1; bus4.rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", N'(bus.busy), 0);
        chk("rst_alu_start", N'(bus.alu_start), 0);
        chk("rst_alu_op", N'(bus.alu_op), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_rsp0_valid", N'(bus.rsp0_valid), 0);
        chk("rst_rsp1_valid", N'(bus.rsp1_valid), 0);
        chk("rst_rsp0_result", bus.rsp0_result, 0);
        chk("rst_req0_ready", N'(bus.req0_ready), 0);
        chk("rst_req1_ready", N'(bus.req1_ready), 0);
`ifdef ALU_SHARE_FLAGS_EN
        chk("rst_rsp0_flags", N'(bus.rsp0_flags), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;

        single_op(0);
        single_op(1);

        // Fresh reset so the tie goes to requester 0.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        glog.delete(); gcyc.delete();
        fork
            drive(0, 2);
            drive(1, 3);
        join
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("simul_grant_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("simul_first", glog[0], 0);
            chk("simul_second", glog[1], 1);
        end

        glog.delete(); gcyc.delete();
        fork
            begin drive(0, 2); drive(0, 5); drive(0, 7); end
            begin drive(1, 3); drive(1, 4); drive(1, 6); end
        join
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("contend_grant_count", glog.size(), 6);
        if (glog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("contend_order", glog[i], i % 2);
                if (i > 0) chk("contend_period", gcyc[i] - gcyc[i-1], LAT + 2);
            end
        end

        glog.delete(); gcyc.delete();
        bus.rsp1_ready = 1'b0;
        drive(1, 6);
        fork
            drive(0, 5);
            begin
                t = 0;
                @(negedge clk);
                while (!bus.rsp1_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                if (!bus.rsp1_valid) tmo("bp_rsp1_valid");
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_rsp1_valid", N'(bus.rsp1_valid), 1);
                    chk("bp_rsp1_result", bus.rsp1_result, tbl[6].exp);
                    chk("bp_busy", N'(bus.busy), 1);
                    chk("bp_req0_blocked", N'(bus.req0_ready), 0);
                end
                @(posedge clk);
                #1 bus.rsp1_ready = 1'b1;
                @(negedge clk);
                hcyc = cyc;
            end
        join
        chk("bp_grant_count", glog.size(), 2);
        if (gcyc.size() == 2) chk("bp_req0_after_hs", gcyc[1] - hcyc, 1);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset in the second EXEC cycle of the LAT=4 instance.
        bus4.req0_op = 4'd1; bus4.req0_a = 32'd1; bus4.req0_b = 32'd2; bus4.req0_valid = 1'b1;
        @(negedge clk);
        chk("r4_accept", N'(bus4.req0_ready), 1);
        @(posedge clk);
        #1 bus4.req0_valid = 1'b0;
        @(negedge clk);
        chk("r4_start", N'(bus4.alu_start), 1);
        @(posedge clk);
        #1 rst4 = 1'b1;
        #1;
        chk("r4_busy", N'(bus4.busy), 0);
        chk("r4_alu_start", N'(bus4.alu_start), 0);
        chk("r4_alu_op", N'(bus4.alu_op), 0);
        chk("r4_alu_a", bus4.alu_a, 0);
        chk("r4_rsp0_valid", N'(bus4.rsp0_valid), 0);
        @(posedge clk);
        #1 rst4 = 1'b0;
        n = 0;
        repeat (LAT4 + 3) begin
            @(negedge clk);
            if (bus4.rsp0_valid) n++;
        end
        chk("r4_no_response", n, 0);
        @(posedge clk);
        #1;
        bus4.req1_op = 4'd2; bus4.req1_a = 32'h1234_5678; bus4.req1_b = 32'hFFFF_0000;
        bus4.req1_valid = 1'b1;
        @(negedge clk);
        chk("r4_req1_ready", N'(bus4.req1_ready), 1);
        chk("r4_req0_ready", N'(bus4.req0_ready), 0);
        @(posedge clk);
        #1 bus4.req1_valid = 1'b0;
        repeat (LAT4) @(negedge clk);
        chk("r4_rsp1_early", N'(bus4.rsp1_valid), 0);
        @(negedge clk);
        chk("r4_rsp1_valid", N'(bus4.rsp1_valid), 1);
        chk("r4_rsp0_quiet", N'(bus4.rsp0_valid), 0);
        chk("r4_rsp1_result", bus4.rsp1_result, 32'hEDCB_5678);
        @(posedge clk);
        #1;

        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares one N-bit ALU datapath between two requesters, typically the integer pipeline and the address/branch unit. It accepts one operation at a time, drives the registered opcode and operands onto the shared ALU for a fixed latency, and captures the result. It then returns the result to the requester that issued it through a valid/ready response channel. It sits between the requesters and the ALU operation modules and their result mux.

## Interface
- N, 32, operand/result width
- OPW, 4, opcode width
- LAT, 1, ALU latency in cycles; legal range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- reqK_valid  in  1  request K (K=0,1) presents an operation
- reqK_ready  out  1  request K accepted this cycle
- reqK_op  in  OPW  opcode
- reqK_a, reqK_b  in  N  operands
- rspK_valid  out  1  result for requester K available
- rspK_ready  in  1  requester K consumes the result
- rspK_result  out  N  result
- rspK_flags  out  4  NZCV; present only with the macro
- alu_start  out  1  one-cycle pulse marking the first execute cycle
- alu_op  out  OPW, alu_a / alu_b  out  N  registered operation to the ALU
- alu_result  in  N  ALU output
- alu_flags  in  4  ALU NZCV; present only with the macro
- busy  out  1  state != IDLE

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Grant is computed combinationally from reqK_valid and the priority pointer `prio`.
  - If both requesters are valid, grant `prio`. Otherwise grant the one that is valid.
  - reqK_ready = (state==IDLE) & grantK. It depends combinationally on valid, and is 0 in every other state.
  - On a grant:
    - Latch op, a and b into alu_op/alu_a/alu_b.
    - Latch the owner id.
    - Set `prio` to the non-granted requester.
    - Clear the counter and go to EXEC.
- **EXEC**
  - alu_start=1 in the first EXEC cycle only. alu_* stay stable throughout.
  - The counter increments each cycle.
  - When counter==LAT-1, capture alu_result (and alu_flags) into the response registers and go to RESP.
- **RESP**
  - rspK_valid=1 for the owner only, held until rspK_ready.
  - rspK_result/flags are stable while valid.
  - On the handshake, go to IDLE. rspK_ready from the non-owner is ignored.
- Requests that arrive outside IDLE are not accepted. Requesters hold valid and payload until ready.
- The result is not modified by this block. Width handling (for example the NOT operation's shifted result) belongs entirely to the ALU.
- **Reset mid-operation:** the operation is aborted, no response is issued, and the requester must re-issue.

## Timing
- Reset values:
  - state=IDLE, prio=0, counter=0.
  - alu_start=0, alu_op/a/b=0.
  - rspK_valid=0, rspK_result=0, rspK_flags=0.
  - busy=0. reqK_ready evaluates to 0 unless valid.
- An accept at edge T gives:
  - EXEC during cycles T+1..T+LAT.
  - Result sampled at the end of cycle T+LAT.
  - rsp_valid high from cycle T+LAT+1.
- With rsp_ready already high, the next accept occurs at cycle T+LAT+2. Peak throughput is 1 operation per LAT+2 cycles.
- There is no RESP→accept bypass. A request valid during RESP waits one cycle in IDLE.
- Counter is 4 bits and never wraps within legal LAT. LAT=1 gives a single EXEC cycle.

## Configuration
- ALU_SHARE_FLAGS_EN
  - **Defined:** the alu_flags input and the rspK_flags outputs exist. Flags are captured on the same edge as the result and held with it.
  - **Undefined:** those ports and registers are removed. Result behaviour and timing are unchanged.

## Test plan
- **Single op:** LAT=2, ALU model is NOT ((~a)>>31).
  - Stimulus: req0 with a=0x0000_0000.
  - Required: accept at T, alu_start at T+1, rsp0_valid at T+3 with rsp0_result=0x0000_0001.
  - Repeat with a=0x8000_0000; required rsp0_result=0x0000_0000.
- **Simultaneous after reset:** req0 and req1 valid together.
  - Required: req0 granted first (prio=0), req1 granted in the next IDLE.
  - Each response goes only to its issuer.
- **Continuous contention:** both requesters always valid for 6 operations.
  - Required: grants alternate 0,1,0,1,0,1, with one grant every LAT+2 cycles when rsp_ready is tied high.
- **Backpressure:** rsp1_ready low for 5 cycles.
  - Required: rsp1_valid/result held stable and busy=1.
  - req0 is not accepted until the cycle after the rsp1 handshake.
- **Reset mid-EXEC:** rst asserted in the second EXEC cycle with LAT=4.
  - Required: all outputs go to their reset values immediately and no response is produced.
  - After release, a new req1 is granted first, because prio=0 has no effect when only req1 is valid.
- **Flags (macro defined):** ALU model drives alu_flags=4'b1000 with the result.
  - Required: rsp0_flags=4'b1000 alongside rsp0_result.
  - Rerun with the macro undefined; results and timing must be identical.
